// File: rtl/gpio_responder_if.sv
// Bus-side interface of the GPIO responder.
//   master : bus arbiter side; drives the strobes, address and write data, receives read data
//   slave  : GPIO responder side
//   memread_gpio   read strobe, one access per cycle it is high
//   memwrite_gpio  write strobe
//   addr_gpio      byte address, only [2:0] decoded by the responder
//   writedata_gpio write data
//   readdata_gpio  registered read data
interface gpio_responder_if;
    logic        memread_gpio;
    logic        memwrite_gpio;
    logic [15:0] addr_gpio;
    logic [7:0]  writedata_gpio;
    logic [7:0]  readdata_gpio;

    modport master (
        output memread_gpio,
        output memwrite_gpio,
        output addr_gpio,
        output writedata_gpio,
        input  readdata_gpio
    );

    modport slave (
        input  memread_gpio,
        input  memwrite_gpio,
        input  addr_gpio,
        input  writedata_gpio,
        output readdata_gpio
    );
endinterface

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO peripheral: output/direction registers, synchronised pin inputs and
// per-bit edge detection with a sticky status register and a level irq.
// Ports:
//   clk      system clock, all state on posedge
//   reset    asynchronous active-low reset
//   bus      gpio_responder_if.slave (strobes, address, write data, registered read data)
//   gpio_in  asynchronous pin inputs
//   gpio_out pin output values (DOUT)
//   gpio_oe  pin output enables (DIR, 1 = drive)
//   irq      registered |(STAT & IEN)
// Register map (addr[2:0]): 0 DOUT, 1 DIR, 2 DIN (RO), 3 IEN, 4 STAT (W1C), 5 EDGE, 6/7 zero.
module gpio_responder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_responder_if.slave      bus,
    input  logic [WIDTH-1:0]     gpio_in,
    output logic [WIDTH-1:0]     gpio_out,
    output logic [WIDTH-1:0]     gpio_oe,
    output logic                 irq
);

    localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [0:0] {StWait, StArmed} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              armed;

    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [WIDTH-1:0]  dir_q, dir_d;
    logic [WIDTH-1:0]  ien_q, ien_d;
    logic [WIDTH-1:0]  stat_q, stat_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  prev_q;
    logic [7:0]        readdata_q, readdata_d;
    logic              irq_q, irq_d;

    logic [2:0]        addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  pin_s;
    logic [WIDTH-1:0]  hit;
    logic [WIDTH-1:0]  w1c;
    logic [7:0]        rdata;

    // Upper address bits and write-data bits above WIDTH are intentionally ignored.
    logic unused_bus;
    assign unused_bus = ^{bus.addr_gpio[15:3], bus.writedata_gpio};

    assign addr  = bus.addr_gpio[2:0];
    assign wdata = bus.writedata_gpio[WIDTH-1:0];
    assign pin_s = sync_q[SYNC_STAGES-1];

    // Arming FSM: hold off edge recording until the synchroniser and prev register have
    // filled with real pin values, so pins already high at reset raise nothing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed   = 1'b0;
        unique case (state_q)
            StWait: begin
                if (cnt_q == CntW'(SYNC_STAGES)) begin
                    state_d = StArmed;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StArmed: armed = 1'b1;
            default: state_d = StWait;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        edge_d = edge_q;
        w1c    = '0;
        if (bus.memwrite_gpio) begin
            case (addr)
                3'd0:    dout_d = wdata;
                3'd1:    dir_d  = wdata;
                3'd3:    ien_d  = wdata;
                3'd4:    w1c    = wdata;
                3'd5:    edge_d = wdata;
                default: ;
            endcase
        end

        // Per-bit select between rising and falling detection.
        hit = (edge_q & pin_s & ~prev_q) | (~edge_q & ~pin_s & prev_q);
        // Clear first, then set, so a new edge wins over a simultaneous W1C.
        stat_d = (stat_q & ~w1c) | (armed ? hit : '0);

        rdata = '0;
        case (addr)
            3'd0:    rdata[WIDTH-1:0] = dout_q;
            3'd1:    rdata[WIDTH-1:0] = dir_q;
            3'd2:    rdata[WIDTH-1:0] = pin_s;
            3'd3:    rdata[WIDTH-1:0] = ien_q;
            3'd4:    rdata[WIDTH-1:0] = stat_q;
            3'd5:    rdata[WIDTH-1:0] = edge_q;
            default: ;
        endcase
        readdata_d = bus.memread_gpio ? rdata : readdata_q;

        irq_d = |(stat_q & ien_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StWait;
            cnt_q      <= '0;
            dout_q     <= '0;
            dir_q      <= '0;
            ien_q      <= '0;
            stat_q     <= '0;
            edge_q     <= '0;
            prev_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dir_q      <= dir_d;
            ien_q      <= ien_d;
            stat_q     <= stat_d;
            edge_q     <= edge_d;
            prev_q     <= pin_s;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            sync_q[0]  <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus.readdata_gpio = readdata_q;
    assign gpio_out          = dout_q;
    assign gpio_oe           = dir_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_gpio_responder.sv
module tb_gpio_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rd_s = 1'b0;
    logic       wr_s = 1'b0;
    logic [15:0] addr_s = '0;
    logic [7:0] wdata_s = '0;
    logic [7:0] pins = 8'hA5;

    logic [7:0] gpio_out8, gpio_oe8;
    logic       irq8;
    logic [3:0] gpio_out4, gpio_oe4;
    logic       irq4;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    gpio_responder_if bus8 ();
    gpio_responder_if bus4 ();

    // Both instances see the same bus traffic; the narrow one is only checked at the end.
    assign bus8.memread_gpio   = rd_s;
    assign bus8.memwrite_gpio  = wr_s;
    assign bus8.addr_gpio      = addr_s;
    assign bus8.writedata_gpio = wdata_s;
    assign bus4.memread_gpio   = rd_s;
    assign bus4.memwrite_gpio  = wr_s;
    assign bus4.addr_gpio      = addr_s;
    assign bus4.writedata_gpio = wdata_s;

    gpio_responder #(.WIDTH(8), .SYNC_STAGES(2)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus8.slave),
        .gpio_in  (pins),
        .gpio_out (gpio_out8),
        .gpio_oe  (gpio_oe8),
        .irq      (irq8)
    );

    gpio_responder #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus4.slave),
        .gpio_in  (pins[3:0]),
        .gpio_out (gpio_out4),
        .gpio_oe  (gpio_oe4),
        .irq      (irq4)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_s    = 1'b1;
        addr_s  = {13'h1000, a};
        wdata_s = d;
        @(posedge clk);
        #1;
        wr_s = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_s   = 1'b1;
        addr_s = {13'h1000, a};
        @(posedge clk);
        #1;
        rd_s = 1'b0;
        check(tag, bus8.readdata_gpio, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset held while strobes toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_s    = i[0];
            wr_s    = ~i[0];
            addr_s  = 16'(i);
            wdata_s = 8'hFF;
            @(posedge clk);
            #1;
            check("rst_rdata", bus8.readdata_gpio, 8'h00);
            check("rst_out", gpio_out8, 8'h00);
            check("rst_oe", gpio_oe8, 8'h00);
            check("rst_irq", {7'b0, irq8}, 8'h00);
        end
        @(negedge clk);
        rd_s  = 1'b0;
        wr_s  = 1'b0;
        reset = 1'b1;
        wait_cycles(5);
        bus_read("din_after_rst", 3'd2, 8'hA5);
        bus_read("stat_after_rst", 3'd4, 8'h00);
        check("irq_after_rst", {7'b0, irq8}, 8'h00);

        // 2: DIR / DOUT
        bus_write(3'd1, 8'hF0);
        check("oe_after_wr", gpio_oe8, 8'hF0);
        bus_write(3'd0, 8'h3C);
        check("out_after_wr", gpio_out8, 8'h3C);
        bus_read("dir_rb", 3'd1, 8'hF0);
        bus_read("dout_rb", 3'd0, 8'h3C);
        wait_cycles(2);
        check("rdata_hold", bus8.readdata_gpio, 8'h3C);

        // 3: rising edge on pin0 with irq enabled
        bus_write(3'd3, 8'h01);
        bus_write(3'd5, 8'h01);
        @(negedge clk);
        pins = 8'hA4;               // falling on bit0 with EDGE[0]=1: no hit
        wait_cycles(5);
        bus_read("stat_no_fall", 3'd4, 8'h00);
        @(negedge clk);
        pins = 8'hA5;
        wait_cycles(3);
        check("irq_before", {7'b0, irq8}, 8'h00);
        wait_cycles(1);
        check("irq_rise", {7'b0, irq8}, 8'h01);
        bus_read("stat_rise", 3'd4, 8'h01);
        bus_write(3'd4, 8'h01);
        check("irq_w1c_lag", {7'b0, irq8}, 8'h01);
        wait_cycles(1);
        check("irq_w1c", {7'b0, irq8}, 8'h00);
        bus_read("stat_cleared", 3'd4, 8'h00);

        // 4: falling detection on pin1
        @(negedge clk);
        pins = 8'hA7;
        wait_cycles(5);
        bus_read("stat_rise_ign", 3'd4, 8'h00);
        @(negedge clk);
        pins = 8'hA5;
        wait_cycles(5);
        bus_read("stat_fall", 3'd4, 8'h02);
        bus_write(3'd4, 8'h02);
        bus_read("stat_fall_clr", 3'd4, 8'h00);
        @(negedge clk);
        pins = 8'hA7;
        wait_cycles(5);
        bus_read("stat_rise_ign2", 3'd4, 8'h00);
        @(negedge clk);
        pins = 8'hA5;               // hit lands on the third edge from here
        @(posedge clk);
        @(posedge clk);
        bus_write(3'd4, 8'h02);     // W1C on that same edge
        bus_read("stat_set_wins", 3'd4, 8'h02);

        // 5: simultaneous read/write, unmapped addresses, read-only DIN
        bus_write(3'd3, 8'h00);
        @(negedge clk);
        rd_s    = 1'b1;
        wr_s    = 1'b1;
        addr_s  = 16'h0203;
        wdata_s = 8'hFF;
        @(posedge clk);
        #1;
        rd_s = 1'b0;
        wr_s = 1'b0;
        check("rw_pre_value", bus8.readdata_gpio, 8'h00);
        bus_read("ien_after_rw", 3'd3, 8'hFF);
        bus_write(3'd6, 8'h55);
        bus_read("addr6", 3'd6, 8'h00);
        bus_read("addr7", 3'd7, 8'h00);
        bus_read("edge_rb", 3'd5, 8'h01);
        bus_write(3'd2, 8'h00);
        bus_read("din_ro", 3'd2, 8'hA5);

        // 6: narrow instance masks upper bits
        bus_write(3'd0, 8'hFF);
        bus_read("dout8_ff", 3'd0, 8'hFF);
        check("dout4_rb", bus4.readdata_gpio, 8'h0F);
        check("out4", {4'h0, gpio_out4}, 8'h0F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
